// File: rtl/sd_weight_loader_ctrl.sv
// -----------------------------------------------------------------------------
// sd_weight_loader_ctrl
//
// Sequences one SD-card file load into an on-chip SNN weight/config memory.
// The controller holds sd_file_reader in reset for a fixed number of cycles,
// releases it, then collects the byte stream it produces. Bytes are packed
// little-endian into memory words and written out through a simple BRAM
// write port. End of file is recognised by a long idle gap after the last
// byte. A missing first byte, too many words, or an abort from the board all
// end the load with a sticky error code.
//
// Ports
//   clk          system clock
//   rstn         synchronous active-low reset
//   start        one-cycle load request, ignored while busy
//   abort        cancel the load in progress
//   busy         high from start acceptance until done or error
//   done         one-cycle pulse on successful completion
//   error        sticky error flag, cleared by the next accepted start
//   err_code     0 none, 1 no data/timeout, 2 overflow, 3 abort
//   reader_rstn  reset for sd_file_reader (active low)
//   sd_outen     byte strobe from sd_file_reader
//   sd_outbyte   byte from sd_file_reader
//   mem_we       memory write strobe, one cycle per word
//   mem_addr     word address, valid with mem_we
//   mem_wdata    packed word, valid with mem_we
//   byte_count   bytes accepted in the current or last load (saturating)
//   word_count   words written in the current or last load
// -----------------------------------------------------------------------------
module sd_weight_loader_ctrl #(
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_W      = 12,
    parameter int MAX_WORDS   = 4096,
    parameter int RST_CYC     = 16,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int EOF_GAP     = 1000000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic                      reader_rstn,
    input  logic                      sd_outen,
    input  logic [7:0]                sd_outbyte,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [8*WORD_BYTES-1:0]   mem_wdata,
    output logic [31:0]               byte_count,
    output logic [ADDR_W:0]           word_count
);

    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int CNT_W  = 32;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_RDR   = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_STREAM    = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_FIN       = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    state_t              state_r;
    // Shared counter: reader reset length in RST_RDR, idle gap afterwards.
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic [DATA_W-1:0]   pack_r;

    logic [DATA_W-1:0]   pack_next_s;
    logic                word_last_s;
    logic [ADDR_W:0]     next_word_s;
    logic                overflow_s;

    // Byte merge into the pack register and word bookkeeping for the next write.
    always_comb begin
        pack_next_s = pack_r;
        pack_next_s[{byte_idx_r, 3'b000} +: 8] = sd_outbyte;
        word_last_s = (byte_idx_r == IDX_W'(WORD_BYTES - 1));
        // A write issued last cycle is not yet in word_count; count it here so
        // back-to-back word completions get consecutive addresses.
        next_word_s = word_count + {{ADDR_W{1'b0}}, mem_we};
        overflow_s  = (byte_idx_r == {IDX_W{1'b0}}) &&
                      (next_word_s >= (ADDR_W + 1)'(MAX_WORDS));
    end

    // Load sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            byte_idx_r  <= {IDX_W{1'b0}};
            pack_r      <= {DATA_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            reader_rstn <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            byte_count  <= 32'd0;
            word_count  <= {(ADDR_W + 1){1'b0}};
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // The word is counted on the edge that retires its write strobe.
            if (mem_we) begin
                word_count <= word_count + {{ADDR_W{1'b0}}, 1'b1};
            end

            case (state_r)
                ST_IDLE: begin
                    reader_rstn <= 1'b0;
                    if (start) begin
                        byte_count <= 32'd0;
                        word_count <= {(ADDR_W + 1){1'b0}};
                        pack_r     <= {DATA_W{1'b0}};
                        byte_idx_r <= {IDX_W{1'b0}};
                        error      <= 1'b0;
                        err_code   <= 2'd0;
                        busy       <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= ST_RST_RDR;
                    end
                end

                ST_RST_RDR: begin
                    if (abort) begin
                        state_r     <= ST_ERR;
                        error       <= 1'b1;
                        err_code    <= ERR_ABORT;
                        busy        <= 1'b0;
                        reader_rstn <= 1'b0;
                    end else if (cnt_r == CNT_W'(RST_CYC - 1)) begin
                        reader_rstn <= 1'b1;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_WAIT_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_WAIT_DATA, ST_STREAM: begin
                    if (abort) begin
                        // Abort wins over a byte in the same cycle: nothing is written.
                        state_r     <= ST_ERR;
                        error       <= 1'b1;
                        err_code    <= ERR_ABORT;
                        busy        <= 1'b0;
                        reader_rstn <= 1'b0;
                    end else if (sd_outen) begin
                        if (overflow_s) begin
                            state_r     <= ST_ERR;
                            error       <= 1'b1;
                            err_code    <= ERR_OVERFLOW;
                            busy        <= 1'b0;
                            reader_rstn <= 1'b0;
                        end else begin
                            state_r <= ST_STREAM;
                            cnt_r   <= {CNT_W{1'b0}};
                            if (byte_count != 32'hFFFF_FFFF) begin
                                byte_count <= byte_count + 32'd1;
                            end
                            if (word_last_s) begin
                                mem_we     <= 1'b1;
                                mem_addr   <= next_word_s[ADDR_W-1:0];
                                mem_wdata  <= pack_next_s;
                                pack_r     <= {DATA_W{1'b0}};
                                byte_idx_r <= {IDX_W{1'b0}};
                            end else begin
                                pack_r     <= pack_next_s;
                                byte_idx_r <= byte_idx_r + IDX_W'(1);
                            end
                        end
                    end else if ((state_r == ST_WAIT_DATA) &&
                                 (cnt_r == CNT_W'(TIMEOUT_CYC - 1))) begin
                        state_r     <= ST_ERR;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        busy        <= 1'b0;
                        reader_rstn <= 1'b0;
                    end else if ((state_r == ST_STREAM) &&
                                 (cnt_r == CNT_W'(EOF_GAP - 1))) begin
                        state_r <= ST_FLUSH;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_FLUSH: begin
                    // End of file already declared; late strobes are dropped.
                    if (abort) begin
                        state_r     <= ST_ERR;
                        error       <= 1'b1;
                        err_code    <= ERR_ABORT;
                        busy        <= 1'b0;
                        reader_rstn <= 1'b0;
                    end else begin
                        if (byte_idx_r != {IDX_W{1'b0}}) begin
                            // Unused high bytes are already zero in pack_r.
                            mem_we    <= 1'b1;
                            mem_addr  <= next_word_s[ADDR_W-1:0];
                            mem_wdata <= pack_r;
                        end
                        pack_r      <= {DATA_W{1'b0}};
                        byte_idx_r  <= {IDX_W{1'b0}};
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        reader_rstn <= 1'b0;
                        state_r     <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    state_r <= ST_IDLE;
                end

                ST_ERR: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                    reader_rstn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_weight_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_weight_loader_ctrl
//
// Directed bench for sd_weight_loader_ctrl with small timing parameters:
// WORD_BYTES=4, ADDR_W=4, MAX_WORDS=2, RST_CYC=16, TIMEOUT_CYC=1000,
// EOF_GAP=50. Memory writes are collected on the falling edge and compared
// with hand-computed words after each load.
// -----------------------------------------------------------------------------
module tb_sd_weight_loader_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        reader_rstn;
    logic        sd_outen;
    logic [7:0]  sd_outbyte;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] byte_count;
    logic [4:0]  word_count;

    int n_tests;
    int n_fail;
    int done_cnt;
    logic [3:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    sd_weight_loader_ctrl #(
        .WORD_BYTES (4),
        .ADDR_W     (4),
        .MAX_WORDS  (2),
        .RST_CYC    (16),
        .TIMEOUT_CYC(1000),
        .EOF_GAP    (50)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .reader_rstn(reader_rstn),
        .sd_outen   (sd_outen),
        .sd_outbyte (sd_outbyte),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .byte_count (byte_count),
        .word_count (word_count)
    );

    // 100 MHz-style free-running clock for simulation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write and done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [3:0] addr, input logic [31:0] data);
        if (idx < wr_data.size()) begin
            check_val({tag, "_addr"}, 64'(wr_addr[idx]), 64'(addr));
            check_val({tag, "_data"}, 64'(wr_data[idx]), 64'(data));
        end else begin
            check_val({tag, "_missing"}, 64'(wr_data.size()), 64'(idx + 1));
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        sd_outen   = 1'b1;
        sd_outbyte = b;
        @(negedge clk);
        sd_outen   = 1'b0;
    endtask

    // Counts falling edges from the current one until the reader is released.
    task automatic wait_reader(output int n);
        n = 0;
        while (!reader_rstn && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("reader_release", 64'(reader_rstn), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        n_tests    = 0;
        n_fail     = 0;
        done_cnt   = 0;
        rstn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        sd_outen   = 1'b0;
        sd_outbyte = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_error", 64'(error), 64'd0);
        check_val("rst_err_code", 64'(err_code), 64'd0);
        check_val("rst_reader_rstn", 64'(reader_rstn), 64'd0);
        check_val("rst_mem_we", 64'(mem_we), 64'd0);
        check_val("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_val("rst_byte_count", 64'(byte_count), 64'd0);
        check_val("rst_word_count", 64'(word_count), 64'd0);
        rstn = 1'b1;
        clear_log();

        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check_val("idle_abort_error", 64'(error), 64'd0);
        check_val("idle_abort_busy", 64'(busy), 64'd0);

        // Test 1: eight bytes -> two full words
        pulse_start();
        check_val("t1_busy", 64'(busy), 64'd1);
        check_val("t1_rdr_low", 64'(reader_rstn), 64'd0);
        wait_reader(n);
        check_val("t1_rst_cycles", 64'(n), 64'd16);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_done();
        repeat (3) @(negedge clk);
        check_val("t1_nwrites", 64'(wr_data.size()), 64'd2);
        check_write("t1_w0", 0, 4'd0, 32'h04030201);
        check_write("t1_w1", 1, 4'd1, 32'h08070605);
        check_val("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_val("t1_byte_count", 64'(byte_count), 64'd8);
        check_val("t1_word_count", 64'(word_count), 64'd2);
        check_val("t1_busy_end", 64'(busy), 64'd0);
        check_val("t1_error", 64'(error), 64'd0);
        clear_log();

        // Test 2: five bytes -> one full word and one padded word
        pulse_start();
        wait_reader(n);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        wait_done();
        repeat (3) @(negedge clk);
        check_val("t2_nwrites", 64'(wr_data.size()), 64'd2);
        check_write("t2_w0", 0, 4'd0, 32'h04030201);
        check_write("t2_w1", 1, 4'd1, 32'h00000005);
        check_val("t2_byte_count", 64'(byte_count), 64'd5);
        check_val("t2_word_count", 64'(word_count), 64'd2);
        check_val("t2_done_cnt", 64'(done_cnt), 64'd1);
        clear_log();

        // Test 3: no data -> timeout
        pulse_start();
        n = 0;
        while (!error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("t3_error", 64'(error), 64'd1);
        check_val("t3_err_code", 64'(err_code), 64'd1);
        check_val("t3_latency_ok", 64'((n >= 1010) && (n <= 1025)), 64'd1);
        check_val("t3_busy", 64'(busy), 64'd0);
        check_val("t3_reader", 64'(reader_rstn), 64'd0);
        check_val("t3_nwrites", 64'(wr_data.size()), 64'd0);
        clear_log();

        // Test 4: twelve bytes with room for two words -> overflow
        pulse_start();
        check_val("t4_error_cleared", 64'(error), 64'd0);
        wait_reader(n);
        for (int i = 1; i <= 12; i++) send_byte(8'(8'h10 + i));
        repeat (3) @(negedge clk);
        check_val("t4_nwrites", 64'(wr_data.size()), 64'd2);
        check_write("t4_w0", 0, 4'd0, 32'h14131211);
        check_write("t4_w1", 1, 4'd1, 32'h18171615);
        check_val("t4_error", 64'(error), 64'd1);
        check_val("t4_err_code", 64'(err_code), 64'd2);
        check_val("t4_word_count", 64'(word_count), 64'd2);
        check_val("t4_byte_count", 64'(byte_count), 64'd8);
        check_val("t4_busy", 64'(busy), 64'd0);
        check_val("t4_done_cnt", 64'(done_cnt), 64'd0);
        clear_log();

        // Test 5: abort after byte 3; a fourth byte coincides with abort
        pulse_start();
        wait_reader(n);
        for (int i = 1; i <= 3; i++) send_byte(8'(i));
        @(negedge clk);
        abort      = 1'b1;
        sd_outen   = 1'b1;
        sd_outbyte = 8'h04;
        @(negedge clk);
        abort    = 1'b0;
        sd_outen = 1'b0;
        check_val("t5_reader", 64'(reader_rstn), 64'd0);
        check_val("t5_error", 64'(error), 64'd1);
        check_val("t5_err_code", 64'(err_code), 64'd3);
        check_val("t5_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_val("t5_nwrites", 64'(wr_data.size()), 64'd0);
        check_val("t5_byte_count", 64'(byte_count), 64'd3);
        clear_log();

        // Test 6: start while busy ignored, reset mid-stream, fresh load
        pulse_start();
        wait_reader(n);
        send_byte(8'h55);
        send_byte(8'h66);
        pulse_start();
        check_val("t6_busy_kept", 64'(busy), 64'd1);
        check_val("t6_reader_kept", 64'(reader_rstn), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_val("t6_rst_busy", 64'(busy), 64'd0);
        check_val("t6_rst_reader", 64'(reader_rstn), 64'd0);
        check_val("t6_rst_byte_count", 64'(byte_count), 64'd0);
        check_val("t6_rst_word_count", 64'(word_count), 64'd0);
        rstn = 1'b1;
        clear_log();
        pulse_start();
        wait_reader(n);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_done();
        repeat (3) @(negedge clk);
        check_val("t6_nwrites", 64'(wr_data.size()), 64'd1);
        check_write("t6_w0", 0, 4'd0, 32'hDDCCBBAA);
        check_val("t6_word_count", 64'(word_count), 64'd1);
        check_val("t6_byte_count", 64'(byte_count), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
